// File: rtl/axi_wr_arb_pkg.sv
// rtl/axi_wr_arb_pkg.sv - shared types and AXI field widths for the write arbiter
package axi_wr_arb_pkg;

  localparam int LEN_W   = 8;
  localparam int SIZE_W  = 3;
  localparam int BURST_W = 2;
  localparam int RESP_W  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/axi_wr_arbiter_rr_arbiter.sv
// rtl/axi_wr_arbiter_rr_arbiter.sv - circular first-after-last_grant request picker
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] grant_idx,
  output logic             valid
);

  logic [IDX_W-1:0] cand;

  // Scan starts one past the previous owner so the previous owner is considered last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    valid     = 1'b0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NREQ);
      if (!valid && req[cand]) begin
        grant[cand] = 1'b1;
        grant_idx   = cand;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_wr_arbiter.sv
// rtl/axi_wr_arbiter.sv - round-robin sharing of one AXI write master port between NREQ requesters
// Optional W length checking is enabled by defining AXI_WR_ARB_LEN_CHECK_EN.
module axi_wr_arbiter
  import axi_wr_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic [NREQ-1:0]                  s_awvalid,
  output logic [NREQ-1:0]                  s_awready,
  input  logic [NREQ-1:0][ADDR_W-1:0]      s_awaddr,
  input  logic [NREQ-1:0][LEN_W-1:0]       s_awlen,
  input  logic [NREQ-1:0][SIZE_W-1:0]      s_awsize,
  input  logic [NREQ-1:0][BURST_W-1:0]     s_awburst,
  input  logic [NREQ-1:0]                  s_wvalid,
  output logic [NREQ-1:0]                  s_wready,
  input  logic [NREQ-1:0][DATA_W-1:0]      s_wdata,
  input  logic [NREQ-1:0]                  s_wlast,
  output logic [NREQ-1:0]                  s_bvalid,
  input  logic [NREQ-1:0]                  s_bready,
  output logic [RESP_W-1:0]                s_bresp,
  output logic [ADDR_W-1:0]                m_awaddr,
  output logic [LEN_W-1:0]                 m_awlen,
  output logic [SIZE_W-1:0]                m_awsize,
  output logic [BURST_W-1:0]               m_awburst,
  output logic                             m_awvalid,
  input  logic                             m_awready,
  output logic [DATA_W-1:0]                m_wdata,
  output logic                             m_wlast,
  output logic                             m_wvalid,
  input  logic                             m_wready,
  input  logic [RESP_W-1:0]                m_bresp,
  input  logic                             m_bvalid,
  output logic                             m_bready,
  output logic [NREQ-1:0]                  grant,
  output logic                             busy,
  output logic                             len_err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] gidx;
  logic [IDX_W-1:0] last_grant;
  logic [NREQ-1:0]  arb_grant;
  logic [IDX_W-1:0] arb_idx;
  logic             arb_valid;
  logic             b_hs;

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req        (s_awvalid),
    .last_grant (last_grant),
    .grant      (arb_grant),
    .grant_idx  (arb_idx),
    .valid      (arb_valid)
  );

  assign b_hs = (state == RESP) && m_bvalid && s_bready[gidx];

`ifdef AXI_WR_ARB_LEN_CHECK_EN
  logic [LEN_W-1:0] beat_cnt;
  logic             gen_last;

  assign gen_last = (beat_cnt == m_awlen);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      beat_cnt <= '0;
    end else if (state == ADDR && m_awready) begin
      beat_cnt <= '0;
    end else if (m_wvalid && m_wready) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_valid) state_nxt = ADDR;
      ADDR:    if (m_awready) state_nxt = DATA;
      DATA:    if (m_wvalid && m_wready && m_wlast) state_nxt = RESP;
      RESP:    if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Every master- and requester-facing strobe is gated by state, so W and B never leak to a non-owner.
  always_comb begin
    s_awready = '0;
    s_wready  = '0;
    s_bvalid  = '0;
    s_bresp   = '0;
    m_awvalid = 1'b0;
    m_wvalid  = 1'b0;
    m_wdata   = '0;
    m_wlast   = 1'b0;
    m_bready  = 1'b0;
    len_err   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      IDLE: s_awready = arb_grant & {NREQ{RESET}};
      ADDR: m_awvalid = 1'b1;
      DATA: begin
        m_wvalid       = s_wvalid[gidx];
        m_wdata        = s_wdata[gidx];
        s_wready[gidx] = m_wready;
`ifdef AXI_WR_ARB_LEN_CHECK_EN
        m_wlast = gen_last;
        len_err = s_wvalid[gidx] && m_wready && (s_wlast[gidx] != gen_last);
`else
        m_wlast = s_wlast[gidx];
`endif
      end
      RESP: begin
        s_bvalid[gidx] = m_bvalid;
        s_bresp        = m_bresp;
        m_bready       = s_bready[gidx];
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IDX_W'(NREQ - 1);
      m_awaddr   <= '0;
      m_awlen    <= '0;
      m_awsize   <= '0;
      m_awburst  <= '0;
    end else begin
      if (state == IDLE && arb_valid) begin
        grant     <= arb_grant;
        gidx      <= arb_idx;
        m_awaddr  <= s_awaddr[arb_idx];
        m_awlen   <= s_awlen[arb_idx];
        m_awsize  <= s_awsize[arb_idx];
        m_awburst <= s_awburst[arb_idx];
      end
      if (b_hs) begin
        last_grant <= gidx;
        grant      <= '0;
      end
    end
  end

endmodule
